// File: rtl/wb_arb_ctrl.sv
// Round-robin Wishbone bus arbiter with per-tenure beat quota and stalled-strobe watchdog.
// Grant is registered (1-cycle latency); quota/watchdog terminations are registered one-cycle pulses.
module wb_arb_ctrl #(
    parameter int MASTERS = 4,
    parameter int QUOTA   = 8,
    parameter int TIMEOUT = 255
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [MASTERS-1:0]     m_cyc_i,
    input  logic [MASTERS-1:0]     m_stb_i,
    input  logic [3*MASTERS-1:0]   m_cti_i,
    input  logic                   s_ack_i,
    input  logic                   s_err_i,
    input  logic                   s_rty_i,
    output logic [MASTERS-1:0]     grant_o,
    output logic [MASTERS-1:0]     arb_err_o,
    output logic [MASTERS-1:0]     arb_rty_o,
    output logic                   s_kill_o,
    output logic                   tmo_o,
    output logic                   busy_o
);

    localparam int IW = (MASTERS > 1) ? $clog2(MASTERS) : 1;
    localparam int BW = (QUOTA > 0) ? $clog2(QUOTA + 1) : 1;
    localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {IDLE, OWN, RELEASE} state_t;

    state_t          state;
    logic            ready;
    logic [IW-1:0]   owner;
    logic [IW-1:0]   last_win;
    logic [BW-1:0]   beat_cnt;
    logic [BW-1:0]   beat_nxt;
    logic [TW-1:0]   wd_cnt;
    logic [TW-1:0]   wd_nxt;
    logic            cti_ok;
    logic            cti_ok_nxt;

    logic [IW-1:0]   cand;
    logic [IW-1:0]   win_idx;
    logic            win_found;
    logic            own_cyc;
    logic            own_stb;
    logic [2:0]      own_cti;
    logic            others;
    logic            slv_term;
    logic            wd_expire;
    logic            quota_fire;
    logic            terminating;

    // Round-robin search starting just after the last winner.
    always_comb begin
        cand      = last_win;
        win_idx   = last_win;
        win_found = 1'b0;
        for (int k = 1; k <= MASTERS; k++) begin
            cand = IW'((int'(last_win) + k) % MASTERS);
            if (!win_found && m_cyc_i[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    assign own_cyc     = m_cyc_i[owner];
    assign own_stb     = m_stb_i[owner];
    assign own_cti     = m_cti_i[3*int'(owner) +: 3];
    assign others      = |(m_cyc_i & ~grant_o);
    assign slv_term    = s_ack_i | s_err_i | s_rty_i;
    assign terminating = |{arb_err_o, arb_rty_o};

    always_comb begin
        beat_nxt   = beat_cnt;
        cti_ok_nxt = cti_ok;
        wd_nxt     = '0;
        if (own_stb && s_ack_i) begin
            if (QUOTA > 0 && beat_cnt != BW'(QUOTA))
                beat_nxt = beat_cnt + 1'b1;
            cti_ok_nxt = (own_cti == 3'b000) || (own_cti == 3'b111);
        end
        if (TIMEOUT > 0 && own_stb && !slv_term)
            wd_nxt = wd_cnt + 1'b1;
    end

    // A slave termination in the expiry cycle keeps the stall count from reaching the limit.
    assign wd_expire  = (TIMEOUT > 0) && own_stb && !slv_term && (wd_cnt == TW'(TIMEOUT - 1));
    // Yield only at a burst boundary and only when someone else is waiting.
    assign quota_fire = (QUOTA > 0) && (beat_nxt == BW'(QUOTA)) && cti_ok_nxt && others;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state     <= IDLE;
            ready     <= 1'b0;
            owner     <= '0;
            last_win  <= IW'(MASTERS - 1);
            beat_cnt  <= '0;
            wd_cnt    <= '0;
            cti_ok    <= 1'b0;
            grant_o   <= '0;
            arb_err_o <= '0;
            arb_rty_o <= '0;
            s_kill_o  <= 1'b0;
            tmo_o     <= 1'b0;
            busy_o    <= 1'b0;
        end else begin
            ready     <= 1'b1;
            arb_err_o <= '0;
            arb_rty_o <= '0;
            s_kill_o  <= 1'b0;
            tmo_o     <= 1'b0;
            case (state)
                // The grant-off turnaround cycle also arbitrates, so back-to-back tenures
                // are separated by exactly one all-zero cycle.
                IDLE, RELEASE: begin
                    state   <= IDLE;
                    grant_o <= '0;
                    busy_o  <= 1'b0;
                    if (ready && win_found) begin
                        state    <= OWN;
                        grant_o  <= MASTERS'(1) << win_idx;
                        busy_o   <= 1'b1;
                        owner    <= win_idx;
                        last_win <= win_idx;
                        beat_cnt <= '0;
                        wd_cnt   <= '0;
                        cti_ok   <= 1'b0;
                    end
                end
                OWN: begin
                    if (terminating || !own_cyc) begin
                        state   <= RELEASE;
                        grant_o <= '0;
                        busy_o  <= 1'b0;
                    end else begin
                        beat_cnt <= beat_nxt;
                        cti_ok   <= cti_ok_nxt;
                        wd_cnt   <= wd_nxt;
                        if (wd_expire) begin
                            arb_err_o <= grant_o;
                            s_kill_o  <= 1'b1;
                            tmo_o     <= 1'b1;
                        end else if (quota_fire) begin
                            arb_rty_o <= grant_o;
                            s_kill_o  <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
